// File: rtl/cmn_alloc_pkg.sv
// -----------------------------------------------------------------------------
// cmn_alloc_pkg
//   Shared types and helpers for the entry-allocation tracker family.
//   - err_code_e : error classification used by scoreboards and monitors.
//   - MAX_ENTRIES: widest one-hot vector idx2oh can produce.
//   - idx2oh     : index -> one-hot decode with range check against n.
// -----------------------------------------------------------------------------
package cmn_alloc_pkg;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_DBL_REL  = 2'd1,
    ERR_CONFLICT = 2'd2
  } err_code_e;

  // Callers slice the low n bits; trackers must have ENTRY_NUM <= MAX_ENTRIES.
  localparam int unsigned MAX_ENTRIES = 256;

  // Returns a one-hot of bit idx, or all zeros when idx is outside [0, n).
  function automatic logic [MAX_ENTRIES-1:0] idx2oh(input int unsigned idx,
                                                     input int unsigned n);
    logic [MAX_ENTRIES-1:0] oh;
    for (int unsigned i = 0; i < MAX_ENTRIES; i++) begin
      oh[i] = (i == idx) && (idx < n);
    end
    return oh;
  endfunction

endpackage

// File: rtl/cmn_lead_one_rev.sv
// -----------------------------------------------------------------------------
// cmn_lead_one_rev
//   Highest-index set-bit detector (leading one searched from the MSB).
//   Ports:
//     v_entry_vld  in  N  candidate vector
//     lead_oh      out N  one-hot of the highest set bit, zero if none
//     lead_bin     out W  binary index of the highest set bit, zero if none
//     lead_vld     out 1  any bit of v_entry_vld is set
// -----------------------------------------------------------------------------
module cmn_lead_one_rev #(
  parameter  int N = 16,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] v_entry_vld,
  output logic [N-1:0] lead_oh,
  output logic [W-1:0] lead_bin,
  output logic         lead_vld
);

  // Ascending scan: the last (highest) set bit overwrites earlier hits.
  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    lead_oh  = '0;
    lead_bin = '0;
    for (int i = 0; i < N; i++) begin
      if (v_entry_vld[i]) begin
        lead_oh    = '0;
        lead_oh[i] = 1'b1;
        lead_bin   = W'(i);
      end
    end
  end

  assign lead_vld = |v_entry_vld;

endmodule

// File: rtl/cmn_entry_alloc_tracker.sv
// -----------------------------------------------------------------------------
// cmn_entry_alloc_tracker
//   Busy/free bitmap for ENTRY_NUM tags. Grants the highest-index free entry
//   (zero latency, one per cycle) and retires entries through REL_PORTS
//   indexed release ports. Tracks occupancy and sticky protocol errors.
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     alloc_req           producer wants one entry this cycle
//     alloc_gnt           combinational grant (alloc_req && a free entry)
//     alloc_idx_bin/_oh   granted index, binary / one-hot (oh zero when full)
//     rel_vld, rel_idx    per-port release strobe and index (AWIDTH per port)
//     flush               clear every entry at the next edge
//     busy_vec, occ_cnt   registered bitmap and its popcount
//     full, empty         registered occupancy flags
//     err_dbl_rel         sticky: release of a free or out-of-range entry
//     err_rel_conflict    sticky: two ports released the same index together
// -----------------------------------------------------------------------------
module cmn_entry_alloc_tracker
  import cmn_alloc_pkg::*;
#(
  parameter  int ENTRY_NUM = 16,
  parameter  int REL_PORTS = 2,
  localparam int AWIDTH    = $clog2(ENTRY_NUM),
  localparam int CWIDTH    = $clog2(ENTRY_NUM + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alloc_req,
  output logic                        alloc_gnt,
  output logic [AWIDTH-1:0]           alloc_idx_bin,
  output logic [ENTRY_NUM-1:0]        alloc_idx_oh,
  input  logic [REL_PORTS-1:0]        rel_vld,
  input  logic [REL_PORTS*AWIDTH-1:0] rel_idx,
  input  logic                        flush,
  output logic [ENTRY_NUM-1:0]        busy_vec,
  output logic [CWIDTH-1:0]           occ_cnt,
  output logic                        full,
  output logic                        empty,
  output logic                        err_dbl_rel,
  output logic                        err_rel_conflict
);

  logic                   free_vld;
  logic [ENTRY_NUM-1:0]   gnt_oh;
  logic [ENTRY_NUM-1:0]   rel_mask;
  logic [ENTRY_NUM-1:0]   busy_nxt;
  logic [CWIDTH-1:0]      occ_nxt;
  logic [AWIDTH-1:0]      rel_idx_p;
  logic [MAX_ENTRIES-1:0] rel_oh_w;
  logic [MAX_ENTRIES-1:0] rel_mask_w;
  logic                   dbl_rel_hit;
  logic                   conflict_hit;

  // ---------------------------------------------------------------------------
  // Allocation: pick from registered state only, so there is no path from
  // release/flush into the grant.
  // ---------------------------------------------------------------------------
  cmn_lead_one_rev #(
    .N (ENTRY_NUM)
  ) u_lead (
    .v_entry_vld (~busy_vec),
    .lead_oh     (alloc_idx_oh),
    .lead_bin    (alloc_idx_bin),
    .lead_vld    (free_vld)
  );

  assign alloc_gnt = alloc_req & free_vld;
  assign gnt_oh    = alloc_gnt ? alloc_idx_oh : '0;

  // ---------------------------------------------------------------------------
  // Release decode. Out-of-range indices decode to zero and therefore miss
  // busy_vec, which reports them as double releases.
  // ---------------------------------------------------------------------------
  always_comb begin
    rel_mask_w   = '0;
    rel_oh_w     = '0;
    rel_idx_p    = '0;
    dbl_rel_hit  = 1'b0;
    conflict_hit = 1'b0;
    for (int p = 0; p < REL_PORTS; p++) begin
      rel_idx_p = rel_idx[p*AWIDTH +: AWIDTH];
      rel_oh_w  = idx2oh(32'(rel_idx_p), ENTRY_NUM);
      if (rel_vld[p]) begin
        if (!(|(rel_oh_w[ENTRY_NUM-1:0] & busy_vec))) dbl_rel_hit = 1'b1;
        if (|(rel_oh_w & rel_mask_w))                 conflict_hit = 1'b1;
        rel_mask_w = rel_mask_w | rel_oh_w;
      end
    end
  end

  assign rel_mask = rel_mask_w[ENTRY_NUM-1:0];

  // Only busy entries are cleared: a stray release of a free entry must not
  // cancel a grant of that same entry in this cycle.
  assign busy_nxt = flush ? '0
                          : (busy_vec | gnt_oh) & ~(rel_mask & busy_vec);

  // Occupancy is the popcount of the next bitmap, so it cannot drift.
  always_comb begin
    occ_nxt = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      occ_nxt = occ_nxt + CWIDTH'(busy_nxt[i]);
    end
  end

  // ---------------------------------------------------------------------------
  // State. The bitmap is a plain flop vector, so it is reset like any other
  // control register.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_vec         <= '0;
      occ_cnt          <= '0;
      full             <= 1'b0;
      empty            <= 1'b1;
      err_dbl_rel      <= 1'b0;
      err_rel_conflict <= 1'b0;
    end else begin
      busy_vec         <= busy_nxt;
      occ_cnt          <= occ_nxt;
      full             <= (occ_nxt == CWIDTH'(ENTRY_NUM));
      empty            <= (occ_nxt == '0);
      err_dbl_rel      <= err_dbl_rel | dbl_rel_hit;
      err_rel_conflict <= err_rel_conflict | conflict_hit;
    end
  end

endmodule

// File: tb/tb_cmn_entry_alloc_tracker.sv
module tb_cmn_entry_alloc_tracker;

  localparam int ENTRY_NUM = 16;
  localparam int REL_PORTS = 2;
  localparam int AWIDTH    = 4;
  localparam int CWIDTH    = 5;

  logic                        clk;
  logic                        rst;
  logic                        alloc_req;
  logic                        alloc_gnt;
  logic [AWIDTH-1:0]           alloc_idx_bin;
  logic [ENTRY_NUM-1:0]        alloc_idx_oh;
  logic [REL_PORTS-1:0]        rel_vld;
  logic [REL_PORTS*AWIDTH-1:0] rel_idx;
  logic                        flush;
  logic [ENTRY_NUM-1:0]        busy_vec;
  logic [CWIDTH-1:0]           occ_cnt;
  logic                        full;
  logic                        empty;
  logic                        err_dbl_rel;
  logic                        err_rel_conflict;

  cmn_entry_alloc_tracker #(
    .ENTRY_NUM (ENTRY_NUM),
    .REL_PORTS (REL_PORTS)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .alloc_req        (alloc_req),
    .alloc_gnt        (alloc_gnt),
    .alloc_idx_bin    (alloc_idx_bin),
    .alloc_idx_oh     (alloc_idx_oh),
    .rel_vld          (rel_vld),
    .rel_idx          (rel_idx),
    .flush            (flush),
    .busy_vec         (busy_vec),
    .occ_cnt          (occ_cnt),
    .full             (full),
    .empty            (empty),
    .err_dbl_rel      (err_dbl_rel),
    .err_rel_conflict (err_rel_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [1:0]  rv;
    logic [3:0]  i0;
    logic [3:0]  i1;
    logic        fl;
    logic        rs;
    logic        gnt;
    logic [3:0]  bin;
    logic [15:0] oh;
    logic        chk_oh;
    logic [15:0] busy;
    logic [4:0]  occ;
    logic        full;
    logic        empty;
    logic        dbl;
    logic        conf;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic req, input logic [1:0] rv,
                              input logic [3:0] i0, input logic [3:0] i1,
                              input logic fl, input logic rs,
                              input logic gnt, input logic [3:0] bin,
                              input logic [15:0] oh, input logic chk_oh,
                              input logic [15:0] busy, input logic [4:0] occ,
                              input logic f, input logic e,
                              input logic dbl, input logic conf);
    vec_t v;
    v.req = req; v.rv = rv; v.i0 = i0; v.i1 = i1; v.fl = fl; v.rs = rs;
    v.gnt = gnt; v.bin = bin; v.oh = oh; v.chk_oh = chk_oh;
    v.busy = busy; v.occ = occ; v.full = f; v.empty = e;
    v.dbl = dbl; v.conf = conf;
    vq.push_back(v);
  endfunction

  // Bitmap with bits 15 down to (15-k) set: state after k+1 allocations from empty.
  function automatic logic [15:0] top_bits(input int k);
    return 16'(32'hFFFF << (15 - k));
  endfunction

  function automatic logic [15:0] one_hot(input int i);
    return 16'(32'h1 << i);
  endfunction

  task automatic drive(input logic req, input logic [1:0] rv, input logic [3:0] i0,
                       input logic [3:0] i1, input logic fl, input logic rs);
    alloc_req = req;
    rel_vld   = rv;
    rel_idx   = {i1, i0};
    flush     = fl;
    rst       = rs;
  endtask

  task automatic check_regs(input string tag, input logic [15:0] busy, input logic [4:0] occ,
                            input logic f, input logic e, input logic dbl, input logic conf);
    check({tag, ".busy_vec"}, 32'(busy_vec), 32'(busy));
    check({tag, ".occ_cnt"}, 32'(occ_cnt), 32'(occ));
    check({tag, ".full"}, 32'(full), 32'(f));
    check({tag, ".empty"}, 32'(empty), 32'(e));
    check({tag, ".err_dbl_rel"}, 32'(err_dbl_rel), 32'(dbl));
    check({tag, ".err_rel_conflict"}, 32'(err_rel_conflict), 32'(conf));
  endtask

  initial begin
    // ---------------- vector table ----------------
    // Fill to full: grants 15 down to 0.
    for (int k = 0; k < 16; k++)
      add(1, 2'b00, 0, 0, 0, 0, 1, 4'(15 - k), one_hot(15 - k), 1,
          top_bits(k), 5'(k + 1), k == 15, 0, 0, 0);
    // Full: no grant, one-hot zero.
    add(1, 2'b00, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 16'hFFFF, 16, 1, 0, 0, 0);
    // Release 7 while requesting: not granted in the release cycle.
    add(1, 2'b01, 7, 0, 0, 0, 0, 0, 16'h0000, 1, 16'hFF7F, 15, 0, 0, 0, 0);
    add(1, 2'b00, 0, 0, 0, 0, 1, 7, 16'h0080, 1, 16'hFFFF, 16, 1, 0, 0, 0);
    // Flush while full with a pending request.
    add(1, 2'b00, 0, 0, 1, 0, 0, 0, 16'h0000, 1, 16'h0000, 0, 0, 1, 0, 0);
    // Build busy = {15,3}: allocate 15..3, then release 14..4 on both ports.
    for (int k = 0; k < 13; k++)
      add(1, 2'b00, 0, 0, 0, 0, 1, 4'(15 - k), one_hot(15 - k), 1,
          top_bits(k), 5'(k + 1), 0, 0, 0, 0);
    add(0, 2'b11, 14, 13, 0, 0, 0, 0, 0, 0, 16'h9FF8, 11, 0, 0, 0, 0);
    add(0, 2'b11, 12, 11, 0, 0, 0, 0, 0, 0, 16'h87F8,  9, 0, 0, 0, 0);
    add(0, 2'b11, 10,  9, 0, 0, 0, 0, 0, 0, 16'h81F8,  7, 0, 0, 0, 0);
    add(0, 2'b11,  8,  7, 0, 0, 0, 0, 0, 0, 16'h8078,  5, 0, 0, 0, 0);
    add(0, 2'b11,  6,  5, 0, 0, 0, 0, 0, 0, 16'h8018,  3, 0, 0, 0, 0);
    add(0, 2'b01,  4,  0, 0, 0, 0, 0, 0, 0, 16'h8008,  2, 0, 0, 0, 0);
    // Alloc + release of 15 and 3 together: grant 14.
    add(1, 2'b11, 15, 3, 0, 0, 1, 14, 16'h4000, 1, 16'h4000, 1, 0, 0, 0, 0);
    // Flush to empty, then release a free entry on port 1.
    add(0, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 0);
    add(0, 2'b10, 0, 5, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 1, 0);
    add(0, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 1, 0);
    // Allocate 15..9.
    for (int k = 0; k < 7; k++)
      add(1, 2'b00, 0, 0, 0, 0, 1, 4'(15 - k), one_hot(15 - k), 1,
          top_bits(k), 5'(k + 1), 0, 0, 1, 0);
    // Both ports release 9: freed once.
    add(0, 2'b11, 9, 9, 0, 0, 0, 0, 0, 0, 16'hFC00, 6, 0, 0, 1, 1);
    // Grant of 9 with a stray release of free 9: alloc wins.
    add(1, 2'b01, 9, 0, 0, 0, 1, 9, 16'h0200, 1, 16'hFE00, 7, 0, 0, 1, 1);
    for (int k = 7; k < 10; k++)
      add(1, 2'b00, 0, 0, 0, 0, 1, 4'(15 - k), one_hot(15 - k), 1,
          top_bits(k), 5'(k + 1), 0, 0, 1, 1);
    // occ=10, flush + alloc: grant asserted but discarded.
    add(1, 2'b00, 0, 0, 1, 0, 1, 5, 16'h0020, 1, 16'h0000, 0, 0, 1, 1, 1);
    add(1, 2'b00, 0, 0, 0, 0, 1, 15, 16'h8000, 1, 16'h8000, 1, 0, 0, 1, 1);
    // Reset overrides alloc and release.
    add(1, 2'b11, 15, 15, 0, 1, 1, 14, 16'h4000, 1, 16'h0000, 0, 0, 1, 0, 0);
    add(1, 2'b00, 0, 0, 0, 0, 1, 15, 16'h8000, 1, 16'h8000, 1, 0, 0, 0, 0);

    // ---------------- reset ----------------
    drive(0, 2'b00, 0, 0, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    check_regs("reset", 16'h0000, 0, 0, 1, 0, 0);
    check("reset.alloc_gnt", 32'(alloc_gnt), 32'(0));
    check("reset.alloc_idx_oh", 32'(alloc_idx_oh), 32'h8000);

    // ---------------- table ----------------
    foreach (vq[n]) begin
      string tag;
      tag = $sformatf("vec%0d", n);
      @(negedge clk);
      drive(vq[n].req, vq[n].rv, vq[n].i0, vq[n].i1, vq[n].fl, vq[n].rs);
      #1;
      check({tag, ".alloc_gnt"}, 32'(alloc_gnt), 32'(vq[n].gnt));
      if (vq[n].chk_oh) check({tag, ".alloc_idx_oh"}, 32'(alloc_idx_oh), 32'(vq[n].oh));
      if (vq[n].gnt)    check({tag, ".alloc_idx_bin"}, 32'(alloc_idx_bin), 32'(vq[n].bin));
      @(posedge clk);
      #1;
      check_regs(tag, vq[n].busy, vq[n].occ, vq[n].full, vq[n].empty, vq[n].dbl, vq[n].conf);
    end

    // ---------------- hand-written: alloc + release of different entries ----------------
    // busy = {15}; request and release 15 together: grant 14, occupancy unchanged.
    @(negedge clk);
    drive(1, 2'b01, 15, 0, 0, 0);
    #1;
    check("swap.alloc_gnt", 32'(alloc_gnt), 32'(1));
    check("swap.alloc_idx_bin", 32'(alloc_idx_bin), 32'(14));
    @(posedge clk);
    #1;
    check_regs("swap", 16'h4000, 1, 0, 0, 0, 0);

    // ---------------- hand-written: flush does not clear errors, rst does ----------------
    @(negedge clk);
    drive(0, 2'b01, 2, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 2'b00, 0, 0, 1, 0);
    @(posedge clk);
    #1;
    check_regs("flush_err", 16'h0000, 0, 0, 1, 1, 0);
    @(negedge clk);
    drive(0, 2'b00, 0, 0, 0, 1);
    @(posedge clk);
    #1;
    check_regs("rst_err", 16'h0000, 0, 0, 1, 0, 0);

    @(negedge clk);
    drive(0, 2'b00, 0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
